audio_dma_sched: RTL and testbench

Schedules VRAM audio DMA slots across up to `CHANNELS` audio channels, sharing one memory read port. It sits between the video timing generator, which marks free audio memory slots, and the audio mixer channels. Those channels raise a fetch request after a DMA start strobe and consume a word on the DMA end strobe. Each slot grants at most one channel, round-robin among requesters.

---
 rtl/audio_dma_sched_if.sv | 11 +
 rtl/audio_dma_sched.sv | 102 ++++++++++
 tb/tb_audio_dma_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dma_sched_if.sv
// Memory read port shared by the audio DMA scheduler: a request/address pair
// held until a single-cycle acknowledge that carries the read data.
interface audio_dma_sched_if;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_data_i;
    logic        mem_ack_i;

    modport master (output mem_req_o, mem_addr_o, input mem_data_i, mem_ack_i);
    modport slave  (input mem_req_o, mem_addr_o, output mem_data_i, mem_ack_i);
endinterface

// File: rtl/audio_dma_sched.sv
// Round-robin scheduler that hands each free VRAM audio slot to at most one
// requesting audio channel and performs that channel's single-word fetch.
module audio_dma_sched #(
    parameter int CHANNELS = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     audio_enable_i,
    input  logic                     slot_i,
    input  logic [CHANNELS-1:0]      chan_fetch_i,
    input  logic [16*CHANNELS-1:0]   chan_addr_i,
    output logic [CHANNELS-1:0]      chan_start_o,
    output logic [CHANNELS-1:0]      chan_end_o,
    output logic [15:0]              chan_word_o,
    output logic                     busy_o,
    audio_dma_sched_if.master        mem
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, START, POLL, READ, FINISH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_last;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             pick_valid;
    logic [15:0]      addr_arr [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_addr
        assign addr_arr[g] = chan_addr_i[16*g +: 16];
    end

    // Scan upward from the channel after the last winner; the first hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = IDX_W'((int'(rr_last) + i) % CHANNELS);
            if (!pick_valid && chan_fetch_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        state_nxt     = state;
        chan_start_o  = '0;
        chan_end_o    = '0;
        busy_o        = (state != IDLE);
        mem.mem_req_o = (state == READ);
        unique case (state)
            IDLE:   if (slot_i && audio_enable_i) state_nxt = START;
            START: begin
                chan_start_o = '1;
                state_nxt    = audio_enable_i ? POLL : IDLE;
            end
            POLL:   state_nxt = (audio_enable_i && pick_valid) ? READ : IDLE;
            READ:   if (mem.mem_ack_i) state_nxt = FINISH;
            FINISH: begin
                for (int i = 0; i < CHANNELS; i++)
                    chan_end_o[i] = (winner == IDX_W'(i));
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rr_last        <= IDX_W'(CHANNELS - 1);
            winner         <= '0;
            mem.mem_addr_o <= '0;
            chan_word_o    <= '0;
        end else begin
            if (state == POLL && audio_enable_i && pick_valid) begin
                winner         <= pick_idx;
                mem.mem_addr_o <= addr_arr[pick_idx];
            end
            if (state == READ && mem.mem_ack_i)
                chan_word_o <= mem.mem_data_i;
            // Priority only advances once the end strobe has actually been issued.
            if (state == FINISH)
                rr_last <= winner;
        end
    end

endmodule

// File: tb/tb_audio_dma_sched.sv
// Self-checking bench for audio_dma_sched: directed timeline checks plus
// randomized slots compared against a round-robin reference model.
module tb_audio_dma_sched;

    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              audio_enable_i;
    logic              slot_i;
    logic [CH-1:0]     chan_fetch_i;
    logic [16*CH-1:0]  chan_addr_i;
    logic [CH-1:0]     chan_start_o;
    logic [CH-1:0]     chan_end_o;
    logic [15:0]       chan_word_o;
    logic              busy_o;

    audio_dma_sched_if mem_bus ();

    int n_vec = 0;
    int n_bad = 0;
    int rr_model;

    audio_dma_sched #(.CHANNELS(CH)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .audio_enable_i (audio_enable_i),
        .slot_i         (slot_i),
        .chan_fetch_i   (chan_fetch_i),
        .chan_addr_i    (chan_addr_i),
        .chan_start_o   (chan_start_o),
        .chan_end_o     (chan_end_o),
        .chan_word_o    (chan_word_o),
        .busy_o         (busy_o),
        .mem            (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        tick;
        reset_i  = 1'b0;
        rr_model = CH - 1;
        tick;
    endtask

    // Reference: first requester strictly after the last winner, with wrap.
    function automatic int model_pick(input logic [CH-1:0] f);
        for (int i = 1; i <= CH; i++) begin
            int c;
            c = (rr_model + i) % CH;
            if (f[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_addrs;
        for (int i = 0; i < CH; i++) chan_addr_i[16*i +: 16] = 16'($urandom);
    endtask

    // Runs one slot; got_chan is -1 when no read happened, -2 on a bad end strobe.
    task automatic do_slot(input logic [CH-1:0] fetch, input int delay, input logic [15:0] data,
                           output int got_chan, output logic [15:0] got_addr,
                           output logic [15:0] got_word, output logic [CH-1:0] got_start);
        chan_fetch_i = fetch;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        got_start = chan_start_o;
        tick;
        tick;
        got_chan = -1;
        got_addr = '0;
        got_word = chan_word_o;
        if (mem_bus.mem_req_o) begin
            got_addr = mem_bus.mem_addr_o;
            repeat (delay) tick;
            mem_bus.mem_ack_i  = 1'b1;
            mem_bus.mem_data_i = data;
            tick;
            mem_bus.mem_ack_i = 1'b0;
            got_word = chan_word_o;
            got_chan = -2;
            for (int i = 0; i < CH; i++)
                if (chan_end_o == CH'(1 << i)) got_chan = i;
            tick;
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tick;
        tick;
        n_vec++;
        if ({chan_start_o, chan_end_o, chan_word_o, mem_bus.mem_req_o, mem_bus.mem_addr_o, busy_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got start=%b end=%b word=%h req=%b addr=%h busy=%b, expected all 0",
                     chan_start_o, chan_end_o, chan_word_o, mem_bus.mem_req_o, mem_bus.mem_addr_o, busy_o);
        end
        reset_i  = 1'b0;
        rr_model = CH - 1;
        tick;
    endtask

    task automatic test_single_grant;
        chan_addr_i[16*2 +: 16] = 16'h1234;
        chan_fetch_i = 4'b0100;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        n_vec++;
        if (chan_start_o !== 4'b1111) begin
            n_bad++; $display("FAIL single_start: got %b expected 1111", chan_start_o);
        end
        tick;
        tick;
        for (int c = 3; c <= 5; c++) begin
            n_vec++;
            if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 16'h1234) begin
                n_bad++;
                $display("FAIL single_addr_c%0d: got req=%b addr=%h expected req=1 addr=1234",
                         c, mem_bus.mem_req_o, mem_bus.mem_addr_o);
            end
            if (c == 5) begin
                mem_bus.mem_ack_i  = 1'b1;
                mem_bus.mem_data_i = 16'hBEEF;
            end
            tick;
        end
        mem_bus.mem_ack_i = 1'b0;
        n_vec++;
        if (chan_end_o !== 4'b0100 || chan_word_o !== 16'hBEEF || mem_bus.mem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: got end=%b word=%h req=%b expected end=0100 word=beef req=0",
                     chan_end_o, chan_word_o, mem_bus.mem_req_o);
        end
        tick;
        n_vec++;
        if (busy_o !== 1'b0 || chan_end_o !== 4'b0000) begin
            n_bad++; $display("FAIL single_idle: got busy=%b end=%b expected 0 0000", busy_o, chan_end_o);
        end
        rr_model = 2;
    endtask

    task automatic test_round_robin;
        int got; logic [15:0] a, w; logic [CH-1:0] s;
        do_reset;
        for (int k = 0; k < 8; k++) begin
            do_slot(4'b1111, 1, 16'(k), got, a, w, s);
            n_vec++;
            if (got !== k % 4) begin
                n_bad++; $display("FAIL round_robin_%0d: got ch %0d expected ch %0d", k, got, k % 4);
            end
            rr_model = k % 4;
        end
    endtask

    task automatic test_reset_mid_read;
        int got; logic [15:0] a, w; logic [CH-1:0] s;
        set_addrs;
        chan_fetch_i = 4'b1111;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        tick;
        tick;
        n_vec++;
        if (mem_bus.mem_req_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_read: got req=%b expected 1", mem_bus.mem_req_o);
        end
        #2 reset_i = 1'b1;
        #1;
        n_vec++;
        if ({chan_start_o, chan_end_o, chan_word_o, mem_bus.mem_req_o, mem_bus.mem_addr_o, busy_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got start=%b end=%b word=%h req=%b addr=%h busy=%b, expected all 0",
                     chan_start_o, chan_end_o, chan_word_o, mem_bus.mem_req_o, mem_bus.mem_addr_o, busy_o);
        end
        tick;
        reset_i  = 1'b0;
        rr_model = CH - 1;
        tick;
        do_slot(4'b1111, 1, 16'h5A5A, got, a, w, s);
        n_vec++;
        if (got !== 0 || a !== chan_addr_i[15:0]) begin
            n_bad++; $display("FAIL reset_first_grant: got ch %0d addr %h expected ch 0 addr %h", got, a, chan_addr_i[15:0]);
        end
        rr_model = 0;
    endtask

    task automatic test_skip_idle;
        int got; logic [15:0] a, w; logic [CH-1:0] s;
        int exp_order [3] = '{1, 3, 1};
        logic [CH-1:0] fetches [3] = '{4'b0010, 4'b1010, 4'b1010};
        for (int k = 0; k < 3; k++) begin
            do_slot(fetches[k], 0, 16'h1000 + 16'(k), got, a, w, s);
            n_vec++;
            if (got !== exp_order[k]) begin
                n_bad++; $display("FAIL skip_idle_%0d: got ch %0d expected ch %0d", k, got, exp_order[k]);
            end
            rr_model = exp_order[k];
        end
    endtask

    task automatic test_no_request;
        logic req_seen;
        chan_fetch_i = '0;
        mem_bus.mem_ack_i = 1'b1;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        n_vec++;
        if (chan_start_o !== 4'b1111) begin
            n_bad++; $display("FAIL noreq_start: got %b expected 1111", chan_start_o);
        end
        req_seen = mem_bus.mem_req_o;
        tick;
        req_seen |= mem_bus.mem_req_o;
        tick;
        req_seen |= mem_bus.mem_req_o;
        n_vec++;
        if (busy_o !== 1'b0 || req_seen !== 1'b0 || chan_end_o !== '0) begin
            n_bad++; $display("FAIL noreq_idle: got busy=%b req_seen=%b end=%b expected 0 0 0000", busy_o, req_seen, chan_end_o);
        end
        mem_bus.mem_ack_i = 1'b0;
        tick;
    endtask

    task automatic test_disable_overlap;
        int ends;
        logic busy_seen;
        // Second slot arriving during READ must be dropped.
        chan_fetch_i = 4'b0001;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        tick;
        tick;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        mem_bus.mem_ack_i = 1'b1;
        ends = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            mem_bus.mem_ack_i = 1'b0;
            if (chan_end_o !== '0) ends++;
        end
        n_vec++;
        if (ends !== 1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL overlap_drop: got %0d end strobes busy=%b expected 1 and 0", ends, busy_o);
        end
        rr_model = 0;
        // Disable during READ still completes.
        chan_fetch_i = 4'b0010;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        tick;
        tick;
        audio_enable_i = 1'b0;
        mem_bus.mem_ack_i  = 1'b1;
        mem_bus.mem_data_i = 16'hC0DE;
        tick;
        mem_bus.mem_ack_i = 1'b0;
        n_vec++;
        if (chan_end_o !== 4'b0010 || chan_word_o !== 16'hC0DE) begin
            n_bad++; $display("FAIL disable_in_read: got end=%b word=%h expected 0010 c0de", chan_end_o, chan_word_o);
        end
        tick;
        rr_model = 1;
        // Slot while disabled is ignored.
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        busy_seen = busy_o;
        repeat (3) begin tick; busy_seen |= busy_o; end
        n_vec++;
        if (busy_seen !== 1'b0) begin
            n_bad++; $display("FAIL disabled_slot: got busy_seen=%b expected 0", busy_seen);
        end
        // Disable dropping in START aborts without a memory access.
        audio_enable_i = 1'b1;
        chan_fetch_i = 4'b1111;
        slot_i = 1'b1;
        tick;
        slot_i = 1'b0;
        audio_enable_i = 1'b0;
        tick;
        busy_seen = busy_o;
        tick;
        busy_seen |= mem_bus.mem_req_o;
        n_vec++;
        if (busy_seen !== 1'b0) begin
            n_bad++; $display("FAIL disable_in_start: got busy_or_req=%b expected 0", busy_seen);
        end
        audio_enable_i = 1'b1;
    endtask

    task automatic test_back_to_back;
        int got; logic [15:0] a, w; logic [CH-1:0] s;
        int exp;
        for (int k = 0; k < 3; k++) begin
            exp = model_pick(4'b1111);
            do_slot(4'b1111, 0, 16'hA000 + 16'(k), got, a, w, s);
            n_vec++;
            if (got !== exp || w !== 16'hA000 + 16'(k) || busy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL back_to_back_%0d: got ch %0d word %h busy %b expected ch %0d word %h busy 0",
                         k, got, w, busy_o, exp, 16'hA000 + 16'(k));
            end
            rr_model = exp;
        end
    endtask

    task automatic test_random;
        int got; logic [15:0] a, w, data, exp_word; logic [CH-1:0] s, f;
        int exp;
        exp_word = chan_word_o;
        for (int k = 0; k < 40; k++) begin
            set_addrs;
            f    = CH'($urandom_range(0, 15));
            data = 16'($urandom);
            exp  = model_pick(f);
            do_slot(f, $urandom_range(0, 3), data, got, a, w, s);
            if (exp >= 0) exp_word = data;
            n_vec++;
            if (got !== exp || s !== 4'b1111 || w !== exp_word ||
                (exp >= 0 && a !== chan_addr_i[16*exp +: 16])) begin
                n_bad++;
                $display("FAIL random_%0d: fetch=%b got ch %0d addr %h word %h start %b expected ch %0d word %h start 1111",
                         k, f, got, a, w, s, exp, exp_word);
            end
            if (exp >= 0) rr_model = exp;
        end
    endtask

    initial begin
        reset_i            = 1'b1;
        audio_enable_i     = 1'b1;
        slot_i             = 1'b0;
        chan_fetch_i       = '0;
        chan_addr_i        = '0;
        mem_bus.mem_ack_i  = 1'b0;
        mem_bus.mem_data_i = '0;
        rr_model           = CH - 1;
        test_reset;
        test_single_grant;
        test_round_robin;
        test_reset_mid_read;
        test_skip_idle;
        test_no_request;
        test_disable_overlap;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
